// File: rtl/tag_pool.sv
// Physical tag free list (2..31) plus per-tag done flags for issue wakeup.
// Latency: alloc_tag is combinational from registered state; flag, count and err updates appear one cycle after the edge.
// Backpressure: alloc_ready drops when the free list is empty; releases into a full list are dropped and flagged in err.
module tag_pool #(
   parameter int NUM_TAGS  = 30,
   parameter int TAG_W     = 5,
   parameter int FIRST_TAG = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alloc_valid,
   output logic                alloc_ready,
   output logic [TAG_W-1:0]    alloc_tag,
   input  logic                wb0_valid,
   input  logic [TAG_W-1:0]    wb0_tag,
   input  logic                wb1_valid,
   input  logic [TAG_W-1:0]    wb1_tag,
   input  logic                rel_valid,
   input  logic [TAG_W-1:0]    rel_tag,
   output logic [NUM_TAGS-1:0] done_flags,
   output logic [TAG_W-1:0]    free_count,
   output logic                err
);
   localparam int PTR_W = $clog2(NUM_TAGS);

   logic [TAG_W-1:0]    fifo_q [NUM_TAGS];
   logic [TAG_W-1:0]    fifo_d [NUM_TAGS];
   logic [PTR_W-1:0]    head_q, head_d;
   logic [PTR_W-1:0]    tail_q, tail_d;
   logic [TAG_W-1:0]    count_q, count_d;
   logic [NUM_TAGS-1:0] flags_q, flags_d;
   logic                err_q, err_d;
   logic                alloc_fire;
   logic                rel_bad;
   logic                rel_ok;
   logic                wb_hit;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NUM_TAGS - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      alloc_ready = (count_q != '0);
      alloc_tag   = fifo_q[head_q];
      alloc_fire  = alloc_valid & alloc_ready;
      // Full-list check uses the count before any same-cycle alloc.
      rel_bad     = rel_valid & ((rel_tag < TAG_W'(FIRST_TAG)) | (count_q == TAG_W'(NUM_TAGS)));
      rel_ok      = rel_valid & ~rel_bad;
      wb_hit      = (wb0_valid & (wb0_tag == alloc_tag)) | (wb1_valid & (wb1_tag == alloc_tag));
   end

   always_comb begin
      fifo_d  = fifo_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + TAG_W'(rel_ok) - TAG_W'(alloc_fire);
      flags_d = flags_q;
      err_d   = err_q | rel_bad | (alloc_fire & wb_hit);
      if (alloc_fire) begin
         head_d = ptr_inc(head_q);
      end
      if (rel_ok) begin
         fifo_d[tail_q] = rel_tag;
         tail_d         = ptr_inc(tail_q);
      end
      // Tags below FIRST_TAG never match an index, so they are ignored; clear beats set.
      for (int k = 0; k < NUM_TAGS; k++) begin
         if ((wb0_valid && wb0_tag == TAG_W'(k + FIRST_TAG)) ||
             (wb1_valid && wb1_tag == TAG_W'(k + FIRST_TAG))) begin
            flags_d[k] = 1'b1;
         end
         if (alloc_fire && alloc_tag == TAG_W'(k + FIRST_TAG)) begin
            flags_d[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            fifo_q[i] <= TAG_W'(FIRST_TAG + i);
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= TAG_W'(NUM_TAGS);
         flags_q <= '1;
         err_q   <= 1'b0;
      end else begin
         fifo_q  <= fifo_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         flags_q <= flags_d;
         err_q   <= err_d;
      end
   end

   assign done_flags = flags_q;
   assign free_count = count_q;
   assign err        = err_q;
endmodule

// File: tb/tb_tag_pool.sv
// Self-checking bench for tag_pool: vector table, directed corner sequences and a random run against a queue model.
module tb_tag_pool;
   logic        clk = 1'b0;
   logic        rst;
   logic        alloc_valid;
   logic        alloc_ready;
   logic [4:0]  alloc_tag;
   logic        wb0_valid;
   logic [4:0]  wb0_tag;
   logic        wb1_valid;
   logic [4:0]  wb1_tag;
   logic        rel_valid;
   logic [4:0]  rel_tag;
   logic [29:0] done_flags;
   logic [4:0]  free_count;
   logic        err;

   tag_pool dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .wb0_valid(wb0_valid), .wb0_tag(wb0_tag),
      .wb1_valid(wb1_valid), .wb1_tag(wb1_tag),
      .rel_valid(rel_valid), .rel_tag(rel_tag),
      .done_flags(done_flags), .free_count(free_count), .err(err)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: free list as a plain queue of tag numbers.
   int          q[$];
   bit [29:0]   mflags;
   bit          merr;
   bit          g;
   int          gt;

   typedef struct {
      bit          av;
      bit          w0v;
      logic [4:0]  w0t;
      bit          w1v;
      logic [4:0]  w1t;
      bit          rv;
      logic [4:0]  rt;
      bit          e_rdy;
      logic [4:0]  e_tag;
      logic [4:0]  e_cnt;
      logic [29:0] e_flags;
      bit          e_err;
   } vec_t;
   vec_t tbl[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic model_step(input bit r, input bit av, input bit w0v, input logic [4:0] w0t,
                             input bit w1v, input logic [4:0] w1t, input bit rv, input logic [4:0] rt,
                             output bit granted, output int gtag);
      int cnt;
      bit fire;
      int t;
      granted = 1'b0;
      gtag    = -1;
      if (r) begin
         q.delete();
         for (int i = 2; i < 32; i++) q.push_back(i);
         mflags = '1;
         merr   = 1'b0;
         return;
      end
      cnt  = q.size();
      fire = av && (cnt > 0);
      t    = fire ? q[0] : -1;
      if (rv && (rt < 2 || cnt == 30)) merr = 1'b1;
      if (fire && ((w0v && int'(w0t) == t) || (w1v && int'(w1t) == t))) merr = 1'b1;
      if (w0v && w0t >= 2) mflags[int'(w0t) - 2] = 1'b1;
      if (w1v && w1t >= 2) mflags[int'(w1t) - 2] = 1'b1;
      if (fire) begin
         mflags[t - 2] = 1'b0;
         void'(q.pop_front());
      end
      if (rv && rt >= 2 && cnt < 30) q.push_back(int'(rt));
      granted = fire;
      gtag    = t;
   endtask

   // Called at a falling edge: drive one cycle of inputs, step the model, land on the next falling edge.
   task automatic cycle(input bit r, input bit av, input bit w0v, input logic [4:0] w0t,
                        input bit w1v, input logic [4:0] w1t, input bit rv, input logic [4:0] rt,
                        output bit granted, output int gtag);
      rst = r; alloc_valid = av;
      wb0_valid = w0v; wb0_tag = w0t;
      wb1_valid = w1v; wb1_tag = w1t;
      rel_valid = rv;  rel_tag = rt;
      model_step(r, av, w0v, w0t, w1v, w1t, rv, rt, granted, gtag);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_model(input string nm);
      chk({nm, ".ready"}, {31'd0, alloc_ready}, {31'd0, q.size() != 0});
      if (q.size() != 0) chk({nm, ".tag"}, {27'd0, alloc_tag}, q[0]);
      chk({nm, ".count"}, {27'd0, free_count}, q.size());
      chk({nm, ".flags"}, {2'd0, done_flags}, {2'd0, mflags});
      chk({nm, ".err"}, {31'd0, err}, {31'd0, merr});
   endtask

   task automatic check_reset_state(input string nm);
      chk({nm, ".ready"}, {31'd0, alloc_ready}, 32'd1);
      chk({nm, ".tag"}, {27'd0, alloc_tag}, 32'd2);
      chk({nm, ".count"}, {27'd0, free_count}, 32'd30);
      chk({nm, ".flags"}, {2'd0, done_flags}, 32'h3FFF_FFFF);
      chk({nm, ".err"}, {31'd0, err}, 32'd0);
   endtask

   int grants[$];
   int rels[$];

   initial begin
      tbl[0] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 5'd29, 30'h3FFFFFFE, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 5'd28, 30'h3FFFFFFD, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 5'd1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd4, 5'd28, 30'h3FFFFFFF, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b1, 5'd4, 5'd29, 30'h3FFFFFFF, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd5, 5'd29, 30'h3FFFFFFB, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd6, 5'd28, 30'h3FFFFFF3, 1'b1};
      tbl[6] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 5'd28, 30'h3FFFFFF3, 1'b1};

      rst = 1'b1; alloc_valid = 1'b0;
      wb0_valid = 1'b0; wb0_tag = '0; wb1_valid = 1'b0; wb1_tag = '0;
      rel_valid = 1'b0; rel_tag = '0;
      @(negedge clk);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, g, gt);
      check_reset_state("reset");

      // Table vectors from reset state.
      foreach (tbl[i]) begin
         cycle(0, tbl[i].av, tbl[i].w0v, tbl[i].w0t, tbl[i].w1v, tbl[i].w1t, tbl[i].rv, tbl[i].rt, g, gt);
         chk($sformatf("vec%0d.ready", i), {31'd0, alloc_ready}, {31'd0, tbl[i].e_rdy});
         chk($sformatf("vec%0d.tag", i), {27'd0, alloc_tag}, {27'd0, tbl[i].e_tag});
         chk($sformatf("vec%0d.count", i), {27'd0, free_count}, {27'd0, tbl[i].e_cnt});
         chk($sformatf("vec%0d.flags", i), {2'd0, done_flags}, {2'd0, tbl[i].e_flags});
         chk($sformatf("vec%0d.err", i), {31'd0, err}, {31'd0, tbl[i].e_err});
      end

      // Drain and exhaust.
      cycle(1, 0, 0, 0, 0, 0, 0, 0, g, gt);
      for (int i = 0; i < 30; i++) begin
         chk($sformatf("drain.grant%0d", i), {27'd0, alloc_tag}, 32'(i + 2));
         cycle(0, 1, 0, 0, 0, 0, 0, 0, g, gt);
      end
      chk("drain.ready", {31'd0, alloc_ready}, 32'd0);
      chk("drain.count", {27'd0, free_count}, 32'd0);
      chk("drain.flags", {2'd0, done_flags}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 0, 0, 0, 0, 0, 0, g, gt);
         check_model("exhausted");
      end

      // Wakeup on both ports, then a writeback to tag 1.
      cycle(0, 0, 1, 5'd7, 1, 5'd31, 0, 0, g, gt);
      chk("wakeup.flags", {2'd0, done_flags}, 32'h2000_0020);
      cycle(0, 0, 1, 5'd1, 0, 0, 0, 0, g, gt);
      chk("wb_tag1.flags", {2'd0, done_flags}, 32'h2000_0020);
      chk("wb_tag1.err", {31'd0, err}, 32'd0);

      // Release into an empty list while alloc is requested: no bypass.
      cycle(0, 1, 0, 0, 0, 0, 1, 5'd9, g, gt);
      chk("empty_rel.nogrant", {31'd0, g}, 32'd0);
      chk("empty_rel.ready", {31'd0, alloc_ready}, 32'd1);
      chk("empty_rel.tag", {27'd0, alloc_tag}, 32'd9);
      chk("empty_rel.count", {27'd0, free_count}, 32'd1);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, g, gt);
      chk("empty_rel.count_after_grant", {27'd0, free_count}, 32'd0);
      cycle(0, 0, 0, 0, 0, 0, 1, 5'd4, g, gt);
      cycle(0, 1, 0, 0, 0, 0, 1, 5'd5, g, gt);
      chk("alloc_rel.count", {27'd0, free_count}, 32'd1);
      chk("alloc_rel.tag", {27'd0, alloc_tag}, 32'd5);
      cycle(0, 1, 0, 0, 0, 0, 1, 5'd6, g, gt);
      chk("alloc_rel2.count", {27'd0, free_count}, 32'd1);
      check_model("alloc_rel2");

      // Wrap-around: alternate alloc and release cycles.
      cycle(1, 0, 0, 0, 0, 0, 0, 0, g, gt);
      for (int k = 0; k < 45; k++) begin
         if (alloc_ready) grants.push_back(int'(alloc_tag));
         cycle(0, 1, 0, 0, 0, 0, 0, 0, g, gt);
         rels.push_back((40 + k) % 30 + 2);
         cycle(0, 0, 0, 0, 0, 0, 1, 5'((40 + k) % 30 + 2), g, gt);
         chk("wrap.count_max", {31'd0, free_count <= 5'd30}, 32'd1);
      end
      check_model("wrap");
      chk("wrap.ngrants", grants.size(), 32'd45);
      if (grants.size() == 45) begin
         for (int j = 0; j < 30; j++) chk($sformatf("wrap.first%0d", j), grants[j], j + 2);
         for (int j = 0; j < 15; j++) chk($sformatf("wrap.reuse%0d", j), grants[30 + j], rels[j]);
      end

      // Overflow release, then reset mid-drain.
      cycle(1, 0, 0, 0, 0, 0, 0, 0, g, gt);
      cycle(0, 0, 0, 0, 0, 0, 1, 5'd5, g, gt);
      chk("overflow.err", {31'd0, err}, 32'd1);
      chk("overflow.count", {27'd0, free_count}, 32'd30);
      chk("overflow.tag", {27'd0, alloc_tag}, 32'd2);
      for (int i = 0; i < 10; i++) cycle(0, 1, 1, 5'(i + 20), 0, 0, 0, 0, g, gt);
      check_model("middrain");
      cycle(1, 1, 0, 0, 0, 0, 1, 5'd3, g, gt);
      check_reset_state("rst_mid");

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         cycle(($urandom_range(99) == 0), ($urandom_range(9) < 6),
               1'($urandom_range(1)), 5'($urandom_range(31)),
               1'($urandom_range(1)), 5'($urandom_range(31)),
               ($urandom_range(9) < 5), 5'($urandom_range(31)), g, gt);
         check_model("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
